// File: rtl/unshim.sv
// unshim: splits each input packet into a metadata beat (first beat) and a payload stream (remaining beats).
module unshim #(
  parameter int DW = 512
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   AXIS_IN_TDATA,
  input  logic            AXIS_IN_TVALID,
  output logic            AXIS_IN_TREADY,
  input  logic [DW/8-1:0] AXIS_IN_TKEEP,
  input  logic            AXIS_IN_TLAST,
  output logic [DW-1:0]   AXIS_OUT_MD_TDATA,
  output logic            AXIS_OUT_MD_TVALID,
  input  logic            AXIS_OUT_MD_TREADY,
  output logic [DW-1:0]   AXIS_OUT_TDATA,
  output logic            AXIS_OUT_TVALID,
  input  logic            AXIS_OUT_TREADY,
  output logic [DW/8-1:0] AXIS_OUT_TKEEP,
  output logic            AXIS_OUT_TLAST,
  output logic [31:0]     PKT_CNT,
  output logic            HDR_ONLY
);
  typedef enum logic {S_HDR, S_BODY} state_t;
  state_t state, state_n;
  logic [DW-1:0] md_data, out_data;
  logic [DW/8-1:0] out_keep;
  logic md_valid, out_valid, out_last, hdr_only;
  logic [31:0] pkt_cnt;
  logic accept, md_load, out_load;
  // Ready looks only at the register the current beat is headed for.
  assign AXIS_IN_TREADY = !reset && (state == S_HDR ? (!md_valid || AXIS_OUT_MD_TREADY)
                                                    : (!out_valid || AXIS_OUT_TREADY));
  assign accept   = AXIS_IN_TVALID && AXIS_IN_TREADY;
  assign md_load  = accept && state == S_HDR;
  assign out_load = accept && state == S_BODY;
  always_comb begin
    state_n = state;
    if (md_load && !AXIS_IN_TLAST) state_n = S_BODY;
    if (out_load && AXIS_IN_TLAST) state_n = S_HDR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_HDR;
      md_data   <= '0;
      md_valid  <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      pkt_cnt   <= '0;
      hdr_only  <= 1'b0;
    end else begin
      state    <= state_n;
      hdr_only <= md_load && AXIS_IN_TLAST;
      if (accept && AXIS_IN_TLAST) pkt_cnt <= pkt_cnt + 32'd1;
      if (md_load) begin
        md_data  <= AXIS_IN_TDATA;
        md_valid <= 1'b1;
      end else if (AXIS_OUT_MD_TREADY) md_valid <= 1'b0;
      if (out_load) begin
        out_data  <= AXIS_IN_TDATA;
        out_keep  <= AXIS_IN_TKEEP;
        out_last  <= AXIS_IN_TLAST;
        out_valid <= 1'b1;
      end else if (AXIS_OUT_TREADY) out_valid <= 1'b0;
    end
  end
  assign AXIS_OUT_MD_TDATA  = md_data;
  assign AXIS_OUT_MD_TVALID = md_valid;
  assign AXIS_OUT_TDATA     = out_data;
  assign AXIS_OUT_TKEEP     = out_keep;
  assign AXIS_OUT_TLAST     = out_last;
  assign AXIS_OUT_TVALID    = out_valid;
  assign PKT_CNT            = pkt_cnt;
  assign HDR_ONLY           = hdr_only;
endmodule

// File: tb/tb_unshim.sv
// tb_unshim: directed and randomized packet checks of unshim against a packet-level scoreboard.
module tb_unshim;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [KW-1:0] in_keep = '0;
  logic in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [DW-1:0] md_data, out_data;
  logic md_valid, out_valid, out_last, hdr_only;
  logic md_ready = 1'b1, out_ready = 1'b1;
  logic [KW-1:0] out_keep;
  logic [31:0] pkt_cnt;
  int checks = 0, errors = 0, hdr_seen = 0;
  bit bp = 1'b0, md_hold = 1'b0, out_hold = 1'b0;
  logic [DW-1:0] exp_md[$];
  beat_t exp_out[$];
  logic [DW-1:0] md_prev;
  beat_t out_prev;

  unshim #(.DW(DW)) dut (
    .clk(clk), .reset(reset),
    .AXIS_IN_TDATA(in_data), .AXIS_IN_TVALID(in_valid), .AXIS_IN_TREADY(in_ready),
    .AXIS_IN_TKEEP(in_keep), .AXIS_IN_TLAST(in_last),
    .AXIS_OUT_MD_TDATA(md_data), .AXIS_OUT_MD_TVALID(md_valid), .AXIS_OUT_MD_TREADY(md_ready),
    .AXIS_OUT_TDATA(out_data), .AXIS_OUT_TVALID(out_valid), .AXIS_OUT_TREADY(out_ready),
    .AXIS_OUT_TKEEP(out_keep), .AXIS_OUT_TLAST(out_last),
    .PKT_CNT(pkt_cnt), .HDR_ONLY(hdr_only)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    if (bp) begin
      md_ready  = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 2) != 0;
    end
  end

  // Scoreboard: every completed output handshake must match the next expected beat.
  always @(negedge clk) begin
    if (hdr_only === 1'b1) hdr_seen++;
    if (md_hold) begin
      chk("md_valid_held", md_valid, 1);
      chk("md_data_stable", md_data, md_prev);
    end
    if (out_hold) begin
      chk("out_valid_held", out_valid, 1);
      chk("out_stable", {out_data, out_keep, out_last}, out_prev);
    end
    if (md_valid === 1'b1 && md_ready) begin
      if (exp_md.size() == 0) chk("md_extra_beat", 1, 0);
      else chk("md_data", md_data, exp_md.pop_front());
    end
    if (out_valid === 1'b1 && out_ready) begin
      if (exp_out.size() == 0) chk("out_extra_beat", 1, 0);
      else begin
        beat_t e;
        e = exp_out.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_keep", out_keep, e.k);
        chk("out_last", out_last, e.l);
      end
    end
    md_hold  = md_valid === 1'b1 && !md_ready;
    out_hold = out_valid === 1'b1 && !out_ready;
    md_prev  = md_data;
    out_prev = '{out_data, out_keep, out_last};
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input bit hdr);
    int n = 0;
    in_data = d; in_keep = k; in_last = l; in_valid = 1'b1;
    if (hdr) exp_md.push_back(d);
    else exp_out.push_back('{d, k, l});
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while ((exp_md.size() != 0 || exp_out.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_md", exp_md.size(), 0);
    chk("drain_out", exp_out.size(), 0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] h;
    do_reset(3);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_md_valid", md_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_md_data", md_data, 0);
    chk("rst_out_data", {out_data, out_keep, out_last}, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_hdr_only", hdr_only, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 4-beat packet, both consumers ready
    h = {64{8'hA5}};
    send_beat(h, '1, 1'b0, 1'b1);
    chk("t1_md_valid", md_valid, 1);
    chk("t1_md_data", md_data, h);
    for (int i = 1; i <= 3; i++) begin
      send_beat({64{8'(8'hD0 + i)}}, '1, i == 3, 1'b0);
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_data", out_data, {64{8'(8'hD0 + i)}});
      chk("t1_out_last", out_last, i == 3);
    end
    chk("t1_pkt_cnt", pkt_cnt, 1);
    drain();

    // header-only packet
    send_beat({16{32'h0BAD_F00D}}, '0, 1'b1, 1'b1);
    chk("t2_hdr_only_hi", hdr_only, 1);
    chk("t2_pkt_cnt", pkt_cnt, 2);
    idle();
    chk("t2_hdr_only_lo", hdr_only, 0);
    chk("t2_no_out", out_valid, 0);
    drain();

    // MD consumer stalls while the next header waits
    md_ready = 1'b0;
    h = {16{32'h1234_5678}};
    send_beat(h, '0, 1'b1, 1'b1);
    in_data = {16{32'h8765_4321}}; in_last = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t3_in_ready_stall", in_ready, 0);
      chk("t3_md_data_held", md_data, h);
      @(posedge clk);
      #1;
    end
    md_ready = 1'b1;
    send_beat({16{32'h8765_4321}}, '0, 1'b0, 1'b1);
    send_beat({16{32'hCAFE_0001}}, 64'hFF, 1'b1, 1'b0);
    drain();
    chk("t3_pkt_cnt", pkt_cnt, 4);

    // 1000 random packets under random backpressure
    do_reset(2);
    hdr_seen = 0;
    bp = 1'b1;
    begin
      int ho = 0;
      for (int p = 0; p < 1000; p++) begin
        int len = $urandom_range(1, 16);
        if (len == 1) ho++;
        send_beat(rnd_data(), {$urandom, $urandom}, len == 1, 1'b1);
        for (int b = 1; b < len; b++) begin
          if ($urandom_range(0, 3) == 0) idle();
          send_beat(rnd_data(), {$urandom, $urandom}, b == len - 1, 1'b0);
        end
      end
      drain();
      chk("rnd_pkt_cnt", pkt_cnt, 1000);
      chk("rnd_hdr_only_cnt", hdr_seen, ho);
    end
    bp = 1'b0;
    md_ready = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset mid-body: held beats are taken on the reset edge, then state restarts
    send_beat(rnd_data(), '1, 1'b0, 1'b1);
    send_beat(rnd_data(), '1, 1'b0, 1'b0);
    in_valid = 1'b0;
    md_ready = 1'b1;
    out_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_md_valid", md_valid, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_pkt_cnt", pkt_cnt, 0);
    h = {16{32'h5EED_0042}};
    send_beat(h, '1, 1'b0, 1'b1);
    chk("mid_rst_hdr_to_md", md_data, h);
    chk("mid_rst_md_valid2", md_valid, 1);
    chk("mid_rst_no_out", out_valid, 0);
    send_beat(rnd_data(), 64'h1, 1'b1, 1'b0);
    drain();
    chk("mid_rst_pkt_cnt2", pkt_cnt, 1);

    // counter wrap
    force dut.pkt_cnt = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.pkt_cnt;
    chk("wrap_preload", pkt_cnt, 32'hFFFF_FFFE);
    send_beat(rnd_data(), '0, 1'b1, 1'b1);
    chk("wrap_max", pkt_cnt, 32'hFFFF_FFFF);
    send_beat(rnd_data(), '0, 1'b1, 1'b1);
    chk("wrap_zero", pkt_cnt, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/unshim.md
# unshim

Stream splitter that separates a combined AXI-Stream packet into a metadata beat and a payload stream. The first beat of every incoming packet is the metadata header, forwarded on the MD output channel; all following beats, through TLAST, are forwarded on the data output channel toward the pingponger side. Both outputs are registered single-entry stages, so the block sustains one beat per cycle with one cycle of latency.

## Interface
- DW, 512: data width in bits for TDATA on all channels; TKEEP is DW/8 bits.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- AXIS_IN_TDATA  in  DW  combined stream data.
- AXIS_IN_TVALID  in  1  input beat valid.
- AXIS_IN_TREADY  out  1  input beat accepted when high together with TVALID.
- AXIS_IN_TKEEP  in  DW/8  byte enables; dropped on header beats, forwarded on body beats.
- AXIS_IN_TLAST  in  1  last beat of packet.
- AXIS_OUT_MD_TDATA  out  DW  metadata beat (header TDATA unmodified).
- AXIS_OUT_MD_TVALID  out  1  metadata valid.
- AXIS_OUT_MD_TREADY  in  1  metadata consumer ready.
- AXIS_OUT_TDATA  out  DW  payload data.
- AXIS_OUT_TVALID  out  1  payload valid.
- AXIS_OUT_TREADY  in  1  payload consumer ready.
- AXIS_OUT_TKEEP  out  DW/8  payload byte enables.
- AXIS_OUT_TLAST  out  1  last payload beat of packet.
- PKT_CNT  out  32  count of completed input packets (TLAST accepted), wraps at 2^32.
- HDR_ONLY  out  1  one-cycle pulse: a header beat arrived with TLAST set (no payload).

## Operation
- FSM states: S_HDR (expecting header), S_BODY (forwarding payload). Reset state is S_HDR.
- S_HDR: AXIS_IN_TREADY = !md_valid | AXIS_OUT_MD_TREADY. On an accepted beat:
  - load the MD register with TDATA and set md_valid;
  - TLAST=0: go to S_BODY;
  - TLAST=1: stay in S_HDR, pulse HDR_ONLY, increment PKT_CNT.
- S_BODY: AXIS_IN_TREADY = !out_valid | AXIS_OUT_TREADY. On an accepted beat:
  - load the data register with TDATA, TKEEP and TLAST, and set out_valid;
  - TLAST=1: return to S_HDR and increment PKT_CNT.
- Output register release: md_valid clears when the MD handshake completes and no new header is loaded in the same cycle. out_valid behaves the same way with its own handshake.
- Output registers are independent, so header N+1 may be accepted while the last payload beat of packet N is still held in the data register.
- Output ordering: MD beat N is presented no later than the first payload beat of packet N.
- Held output data stays stable while its VALID is high and its READY is low (AXI-S rule). VALID never drops without a handshake.
- Header TKEEP is discarded. Header TLAST affects only FSM, PKT_CNT and HDR_ONLY.
- PKT_CNT is a free-running 32-bit counter with natural wrap, 0xFFFFFFFF -> 0.

## Timing
- Reset (synchronous, active-high, sampled on clk): state=S_HDR, both VALIDs=0, all output TDATA/TKEEP/TLAST=0, PKT_CNT=0, HDR_ONLY=0.
- AXIS_IN_TREADY is 0 while reset is asserted.
- Reset mid-packet discards any partially forwarded packet. The next accepted beat after reset is treated as a header.
- Latency: an input accepted in cycle t appears on its output with VALID=1 in cycle t+1.
- Throughput: 1 beat/cycle when the addressed consumer keeps READY high.
- AXIS_IN_TREADY depends combinationally on the current state and on the addressed output's READY/VALID only. It never depends on AXIS_IN_TVALID.
- HDR_ONLY is asserted in the cycle after the accepting edge, for exactly one cycle. PKT_CNT updates on that same edge.
- Simultaneous output handshake and new load on the same register: the new beat replaces the old one, VALID stays 1, and no bubble is inserted.

## Test plan
- Reset, then send a 4-beat packet (header 0xA5…, body D1–D3, TLAST on D3) with both READYs high -> one MD beat 0xA5… at t+1; D1–D3 on consecutive cycles with TLAST on D3 only; PKT_CNT=1.
- Header-only packet (TLAST on header) -> MD beat emitted, no data beat, HDR_ONLY high for exactly 1 cycle, PKT_CNT increments, FSM back in S_HDR.
- Hold AXIS_OUT_MD_TREADY=0 for 5 cycles after a header -> AXIS_IN_TREADY=0 in S_HDR; MD TDATA stable; no loss or duplication after READY rises.
- Random backpressure on both outputs over 1000 random-length packets (1–16 beats, random TKEEP) -> scoreboard matches every header and payload beat, TKEEP and TLAST exactly; PKT_CNT=1000.
- Reset asserted for 1 cycle in the middle of a packet's body -> all VALIDs=0 and PKT_CNT=0 next cycle; the following beat is routed to MD.
- Preload PKT_CNT near 0xFFFFFFFE via 2 packets after force, or test-mode wrap -> counter reads 0xFFFFFFFF, then 0x00000000.
